// File: rtl/lbrc_pkg.sv
// Shared types and helpers for the line-buffer read controller.
// Holds the FSM state encoding, the row-to-bank mapping used by both the
// write and read sides, and the default image geometry.
package lbrc_pkg;

   localparam int IMG_W_DEF = 28;
   localparam int IMG_H_DEF = 28;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      READ = 2'd2,
      DONE = 2'd3
   } lbrc_state_e;

   // Row k lives in bank (k+3) mod 4; only the two low row bits matter
   function automatic logic [1:0] rowToBank(input logic [1:0] rowLsb);
      return rowLsb + 2'd3;
   endfunction

endpackage

// File: rtl/lbrc_edge_det.sv
// Falling-edge detector on the write-side data enable.
// row_end is high in the cycle where de_in is low after having been
// sampled high on the previous clock edge, so it marks the end of a row.
module lbrc_edge_det (
   input  logic clk,
   input  logic RESET,
   input  logic de_in,
   output logic row_end
);

   logic de_q;

   // Remember last sampled data-enable so a 1 -> 0 transition can be seen
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         de_q <= 1'b0;
      end else begin
         de_q <= de_in;
      end
   end

   assign row_end = de_q & ~de_in;

endmodule

// File: rtl/linebuf_rd_ctrl.sv
// Read-side controller for a four-bank line buffer feeding a 3-row window.
// After each completed row (once three rows are stored) it issues one burst
// of IMG_W reads to the three banks holding the window rows, while the fourth
// bank remains free for the incoming row.
// Optional feature: define LBRC_OVERRUN_EN to add the sticky err_overrun
// output, set when a row ends while a burst is still in progress.
module linebuf_rd_ctrl
   import lbrc_pkg::*;
#(
   parameter int IMG_W  = IMG_W_DEF,
   parameter int IMG_H  = IMG_H_DEF,
   parameter int ADDR_W = 5
)(
   input  logic              clk,
   input  logic              RESET,
   input  logic              start,
   input  logic              de_in,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [3:0]        rden,
   output logic [1:0]        sel_top,
   output logic [1:0]        sel_mid,
   output logic [1:0]        sel_bot,
   output logic              win_valid,
   output logic [ADDR_W-1:0] win_col,
   output logic [11:0]       win_row,
   output logic              busy,
   output logic              frame_done
`ifdef LBRC_OVERRUN_EN
   ,output logic             err_overrun
`endif
);

   lbrc_state_e       state_q;
   logic [11:0]       rc_q;
   logic [11:0]       rc_d;
   logic [ADDR_W-1:0] rdAddr_q;
   logic [3:0]        rden_q;
   logic [1:0]        selTop_q;
   logic [1:0]        selMid_q;
   logic [1:0]        selBot_q;
   logic              winValid_q;
   logic [ADDR_W-1:0] winCol_q;
   logic [11:0]       winRow_q;
   logic              busy_q;
   logic              frameDone_q;
`ifdef LBRC_OVERRUN_EN
   logic              errOverrun_q;
`endif

   logic              rowEnd;
   logic              rowCounted;
   logic [1:0]        topBank;
   logic [1:0]        midBank;
   logic [1:0]        botBank;
   logic [3:0]        winMask;
   logic              lastAddr;
   logic              lastWindow;

   lbrc_edge_det u_edge_det (
      .clk     (clk),
      .RESET   (RESET),
      .de_in   (de_in),
      .row_end (rowEnd)
   );

   // Next row count: start clears it and beats a simultaneous row end;
   // the count stops at IMG_H so a runaway write side cannot wrap it
   always_comb begin
      rc_d       = rc_q;
      rowCounted = rowEnd && (rc_q < 12'(IMG_H));
      if (start) begin
         rc_d = '0;
      end else if (rowCounted) begin
         rc_d = rc_q + 12'd1;
      end
   end

   // Window rows are rc-3, rc-2, rc-1 of the count that results from this row end
   assign topBank    = rowToBank(rc_d[1:0] - 2'd3);
   assign midBank    = rowToBank(rc_d[1:0] - 2'd2);
   assign botBank    = rowToBank(rc_d[1:0] - 2'd1);
   assign winMask    = (4'b0001 << topBank) | (4'b0001 << midBank) | (4'b0001 << botBank);
   assign lastAddr   = (rdAddr_q == ADDR_W'(IMG_W - 1));
   assign lastWindow = (winRow_q == 12'(IMG_H - 2));

   // Frame sequencing FSM with all outputs registered; win_valid/win_col
   // trail rden/rd_addr by one cycle to line up with the BRAM read latency
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         state_q      <= IDLE;
         rc_q         <= '0;
         rdAddr_q     <= '0;
         rden_q       <= '0;
         selTop_q     <= 2'd0;
         selMid_q     <= 2'd1;
         selBot_q     <= 2'd2;
         winValid_q   <= 1'b0;
         winCol_q     <= '0;
         winRow_q     <= '0;
         busy_q       <= 1'b0;
         frameDone_q  <= 1'b0;
`ifdef LBRC_OVERRUN_EN
         errOverrun_q <= 1'b0;
`endif
      end else begin
         rc_q        <= rc_d;
         winValid_q  <= |rden_q;
         winCol_q    <= rdAddr_q;
         frameDone_q <= 1'b0;
         if (start) begin
            state_q      <= FILL;
            rdAddr_q     <= '0;
            rden_q       <= '0;
            winRow_q     <= '0;
            busy_q       <= 1'b0;
`ifdef LBRC_OVERRUN_EN
            errOverrun_q <= 1'b0;
`endif
         end else begin
            case (state_q)
               IDLE: begin
                  state_q <= IDLE;
               end
               FILL: begin
                  if (rowCounted && (rc_d >= 12'd3)) begin
                     state_q  <= READ;
                     rdAddr_q <= '0;
                     rden_q   <= winMask;
                     selTop_q <= topBank;
                     selMid_q <= midBank;
                     selBot_q <= botBank;
                     winRow_q <= rc_d - 12'd2;
                     busy_q   <= 1'b1;
                  end
               end
               READ: begin
`ifdef LBRC_OVERRUN_EN
                  if (rowEnd) begin
                     errOverrun_q <= 1'b1;
                  end
`endif
                  if (lastAddr) begin
                     rdAddr_q <= '0;
                     rden_q   <= '0;
                     busy_q   <= 1'b0;
                     state_q  <= lastWindow ? DONE : FILL;
                  end else begin
                     rdAddr_q <= rdAddr_q + 1'b1;
                  end
               end
               DONE: begin
                  frameDone_q <= 1'b1;
                  state_q     <= IDLE;
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign rd_addr     = rdAddr_q;
   assign rden        = rden_q;
   assign sel_top     = selTop_q;
   assign sel_mid     = selMid_q;
   assign sel_bot     = selBot_q;
   assign win_valid   = winValid_q;
   assign win_col     = winCol_q;
   assign win_row     = winRow_q;
   assign busy        = busy_q;
   assign frame_done  = frameDone_q;
`ifdef LBRC_OVERRUN_EN
   assign err_overrun = errOverrun_q;
`endif

endmodule

// File: tb/tb_linebuf_rd_ctrl.sv
// Self-checking bench for linebuf_rd_ctrl.
// Expected window banks, masks and row indices come from the row -> bank
// rule (k+3) mod 4 applied to the bench's own count of completed rows.
// Build with LBRC_OVERRUN_EN defined to also exercise err_overrun.
module tb_linebuf_rd_ctrl;

   localparam int IMG_W  = 28;
   localparam int IMG_H  = 28;
   localparam int ADDR_W = 5;

   logic              clk = 1'b0;
   logic              RESET = 1'b1;
   logic              start = 1'b0;
   logic              de_in = 1'b0;
   logic [ADDR_W-1:0] rd_addr;
   logic [3:0]        rden;
   logic [1:0]        sel_top;
   logic [1:0]        sel_mid;
   logic [1:0]        sel_bot;
   logic              win_valid;
   logic [ADDR_W-1:0] win_col;
   logic [11:0]       win_row;
   logic              busy;
   logic              frame_done;
`ifdef LBRC_OVERRUN_EN
   logic              err_overrun;
`endif

   int   total = 0;
   int   bad = 0;
   int   burstCount = 0;
   int   doneCount = 0;
   logic prevBusy = 1'b0;

   // Free-running clock
   always #5 clk = ~clk;

   linebuf_rd_ctrl #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk        (clk),
      .RESET      (RESET),
      .start      (start),
      .de_in      (de_in),
      .rd_addr    (rd_addr),
      .rden       (rden),
      .sel_top    (sel_top),
      .sel_mid    (sel_mid),
      .sel_bot    (sel_bot),
      .win_valid  (win_valid),
      .win_col    (win_col),
      .win_row    (win_row),
      .busy       (busy),
      .frame_done (frame_done)
`ifdef LBRC_OVERRUN_EN
      ,.err_overrun (err_overrun)
`endif
   );

   // Count burst starts and end-of-frame pulses independently of the directed checks
   always @(negedge clk) begin
      if (busy && !prevBusy) burstCount <= burstCount + 1;
      if (frame_done) doneCount <= doneCount + 1;
      prevBusy <= busy;
   end

   function automatic int bankOf(input int row);
      return (row + 3) % 4;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One row on the write side: de_in high for len sampled cycles, then low
   task automatic applyStimulus(input int len);
      @(posedge clk);
      #1 de_in = 1'b1;
      repeat (len) @(posedge clk);
      #1 de_in = 1'b0;
   endtask

   task automatic pulseStart();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_rd_addr"},    32'(rd_addr),    32'd0);
      checkOutput({tag, "_rden"},       32'(rden),       32'd0);
      checkOutput({tag, "_sel_top"},    32'(sel_top),    32'd0);
      checkOutput({tag, "_sel_mid"},    32'(sel_mid),    32'd1);
      checkOutput({tag, "_sel_bot"},    32'(sel_bot),    32'd2);
      checkOutput({tag, "_win_valid"},  32'(win_valid),  32'd0);
      checkOutput({tag, "_win_col"},    32'(win_col),    32'd0);
      checkOutput({tag, "_win_row"},    32'(win_row),    32'd0);
      checkOutput({tag, "_busy"},       32'(busy),       32'd0);
      checkOutput({tag, "_frame_done"}, 32'(frame_done), 32'd0);
`ifdef LBRC_OVERRUN_EN
      checkOutput({tag, "_err_overrun"}, 32'(err_overrun), 32'd0);
`endif
   endtask

   // Follow one burst from the row-end edge; k is the row count after that row
   // end. A short extra row can be injected starting at address injectAt.
   task automatic checkBurst(input int k, input int injectAt);
      int top = k - 3;
      int mid = k - 2;
      int bot = k - 1;
      int mask;
      mask = (1 << bankOf(top)) | (1 << bankOf(mid)) | (1 << bankOf(bot));
      @(posedge clk);
      @(negedge clk);
      checkOutput("entry_busy",    32'(busy),    32'd1);
      checkOutput("entry_sel_top", 32'(sel_top), 32'(bankOf(top)));
      checkOutput("entry_sel_mid", 32'(sel_mid), 32'(bankOf(mid)));
      checkOutput("entry_sel_bot", 32'(sel_bot), 32'(bankOf(bot)));
      checkOutput("entry_win_row", 32'(win_row), 32'(mid));
      for (int i = 0; i < IMG_W; i++) begin
         checkOutput("rd_addr", 32'(rd_addr), 32'(i));
         checkOutput("rden",    32'(rden),    32'(mask));
         if (i > 0) checkOutput("win_valid_col", 32'({win_valid, win_col}), 32'((1 << ADDR_W) | (i - 1)));
         if (injectAt >= 0 && i == injectAt) de_in = 1'b1;
         if (injectAt >= 0 && i == injectAt + 3) de_in = 1'b0;
         @(negedge clk);
      end
      checkOutput("end_busy",      32'(busy), 32'd0);
      checkOutput("end_rden",      32'(rden), 32'd0);
      checkOutput("end_valid_col", 32'({win_valid, win_col}), 32'((1 << ADDR_W) | (IMG_W - 1)));
      checkOutput("end_sel_hold",  32'({sel_top, sel_mid, sel_bot}),
                  32'((bankOf(top) << 4) | (bankOf(mid) << 2) | bankOf(bot)));
      if (k == IMG_H) begin
         checkOutput("done_not_early", 32'(frame_done), 32'd0);
         @(negedge clk);
         checkOutput("frame_done",     32'(frame_done), 32'd1);
         checkOutput("valid_after_fd", 32'(win_valid),  32'd0);
         @(negedge clk);
         checkOutput("frame_done_one", 32'(frame_done), 32'd0);
      end else begin
         checkOutput("no_frame_done", 32'(frame_done), 32'd0);
      end
   endtask

   // Directed sequence with randomized row lengths and gaps
   initial begin
      int base;
      int baseDone;
      int rows;
      int len;
      bit found;
      bit seen;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkResetValues("por");
      RESET = 1'b0;

      // Without start the controller stays idle whatever the write side does
      base = burstCount;
      for (int r = 0; r < 4; r++) begin
         applyStimulus($urandom_range(3, IMG_W));
         repeat ($urandom_range(2, 8)) @(posedge clk);
      end
      @(negedge clk);
      checkOutput("idle_no_burst", 32'(burstCount - base), 32'd0);
      checkOutput("idle_busy",     32'(busy),              32'd0);

      // Full frame: IMG_H - 2 bursts and one frame_done pulse
      base = burstCount;
      baseDone = doneCount;
      pulseStart();
      rows = 0;
      for (int r = 0; r < IMG_H; r++) begin
         len = (r < 3) ? IMG_W : int'($urandom_range(2, IMG_W));
         applyStimulus(len);
         rows++;
         if (rows >= 3) begin
            checkBurst(rows, -1);
            repeat ($urandom_range(1, 6)) @(posedge clk);
         end else begin
            repeat (10) @(posedge clk);
            @(negedge clk);
            checkOutput("fill_busy", 32'(busy), 32'd0);
         end
      end
      repeat (5) @(posedge clk);
      @(negedge clk);
      checkOutput("frame_bursts", 32'(burstCount - base),    32'(IMG_H - 2));
      checkOutput("frame_dones",  32'(doneCount - baseDone), 32'd1);

      // Asynchronous reset in the middle of a burst
      pulseStart();
      applyStimulus(IMG_W); repeat (10) @(posedge clk);
      applyStimulus(IMG_W); repeat (10) @(posedge clk);
      applyStimulus(IMG_W);
      found = 1'b0;
      for (int n = 0; n < 60 && !found; n++) begin
         @(negedge clk);
         if (busy === 1'b1 && rd_addr === ADDR_W'(13)) found = 1'b1;
      end
      checkOutput("reach_addr13", 32'(found), 32'd1);
      RESET = 1'b1;
      #1 checkResetValues("async_rst");
      @(negedge clk);
      RESET = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (win_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      checkOutput("quiet_after_rst", 32'(seen), 32'd0);

      // start coinciding with a row end during a burst: start wins, count restarts at 0
      pulseStart();
      applyStimulus(IMG_W); repeat (10) @(posedge clk);
      applyStimulus(IMG_W); repeat (10) @(posedge clk);
      applyStimulus(IMG_W);
      @(posedge clk);
      @(negedge clk);
      checkOutput("coinc_in_read", 32'(busy), 32'd1);
      repeat (3) @(negedge clk);
      de_in = 1'b1;
      repeat (4) @(negedge clk);
      de_in = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      checkOutput("coinc_rden",    32'(rden),    32'd0);
      checkOutput("coinc_busy",    32'(busy),    32'd0);
      checkOutput("coinc_win_row", 32'(win_row), 32'd0);
`ifdef LBRC_OVERRUN_EN
      checkOutput("coinc_err", 32'(err_overrun), 32'd0);
`endif
      applyStimulus(IMG_W); repeat (10) @(posedge clk);
      applyStimulus(IMG_W); repeat (10) @(posedge clk);
      applyStimulus(IMG_W);
      checkBurst(3, -1);

      // Row end during a burst: burst runs to completion, no extra burst queued
      pulseStart();
      applyStimulus(IMG_W); repeat (10) @(posedge clk);
      applyStimulus(IMG_W); repeat (10) @(posedge clk);
      applyStimulus(IMG_W);
      base = burstCount;
      checkBurst(3, int'($urandom_range(2, 15)));
`ifdef LBRC_OVERRUN_EN
      checkOutput("overrun_set", 32'(err_overrun), 32'd1);
`endif
      repeat (40) @(posedge clk);
      @(negedge clk);
      checkOutput("no_queued_burst", 32'(burstCount - base), 32'd1);
      checkOutput("overrun_idle",    32'(busy),              32'd0);
`ifdef LBRC_OVERRUN_EN
      checkOutput("overrun_held", 32'(err_overrun), 32'd1);
`endif
      applyStimulus($urandom_range(2, IMG_W));
      checkBurst(5, -1);
      pulseStart();
      @(negedge clk);
      checkOutput("after_start_busy", 32'(busy), 32'd0);
`ifdef LBRC_OVERRUN_EN
      checkOutput("overrun_cleared", 32'(err_overrun), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
